ct_pmp_napot_enc: RTL
=====================

# ct_pmp_napot_enc

Sequential PMP region encoder on the CSR/firmware-assist side of the PMP unit: the programming counterpart of the per-entry hit comparator. It accepts a physical region as a 4KB-page range [base, top) and emits the pmpaddr value(s) and address-match mode that make an entry hit exactly that range. Naturally aligned power-of-two ranges become one NAPOT entry; other ranges become a TOR entry pair when enabled. Results stream to the pmpcfg/pmpaddr write sequencer over a valid/ready handshake.

## Interface
- ADDR_WIDTH, `PA_WIDTH-12 (28): page-number width; the pmpaddr value is ADDR_WIDTH+1 bits, bit 0 is the NAPOT granule bit.
- cpuclk  in  1  core clock; all state on rising edge.
- cpurst  in  1  asynchronous, active-high reset.
- req_vld  in  1  region request valid.
- req_rdy  out  1  encoder idle, request accepted when req_vld&&req_rdy.
- req_base  in  ADDR_WIDTH  first page of region.
- req_top  in  ADDR_WIDTH+1  exclusive end page (2^ADDR_WIDTH allowed).
- flush  in  1  synchronous abort; drops any in-flight result.
- rslt_vld  out  1  result beat valid.
- rslt_rdy  in  1  consumer accepts beat.
- rslt_pmpaddr  out  ADDR_WIDTH+1  pmpaddr value for the entry.
- rslt_mode  out  2  00 OFF, 01 TOR, 11 NAPOT (10 never produced).
- rslt_last  out  1  final beat of this request.
- rslt_err  out  1  region not encodable; single beat, mode 00, pmpaddr 0.

## Operation
- States: IDLE, CALC, OUT0, OUT1. Reset -> IDLE.
- IDLE: req_rdy=1. Accept -> register base/top -> CALC.
- CALC (one cycle): len=top-base (ADDR_WIDTH+1 bits). err if top<=base. NAPOT-eligible if len is a power of two 2^n and base[n-1:0]==0 (n=0 trivially aligned). Go to OUT0.
- NAPOT encoding: pmpaddr[ADDR_WIDTH:1]=base, then bits [n-1:0] forced to 1, bit n forced to 0. n=ADDR_WIDTH gives 0 followed by ADDR_WIDTH ones. mode=11, last=1.
- Non-eligible, no err: OUT0 emits {base,1'b0}, mode 00, last=0 (bottom entry i-1); OUT1 emits {top[ADDR_WIDTH-1:0],1'b0}, mode 01, last=1 (entry i). top==2^ADDR_WIDTH on this path is err (not representable in TOR).
- err beat: pmpaddr 0, mode 00, err=1, last=1.
- Beat completes on rslt_vld&&rslt_rdy; after last beat -> IDLE, else OUT0 -> OUT1.
- flush: from any state -> IDLE next cycle, rslt_vld deasserted, no beat considered delivered; flush wins over a same-cycle req or handshake.

## Timing
- Reset values: state IDLE, req_rdy 1, rslt_vld 0, rslt_pmpaddr 0, rslt_mode 00, rslt_last 0, rslt_err 0.
- Request accepted cycle T -> CALC T+1 -> rslt_vld from T+2.
- All rslt_* registered; held stable while rslt_vld&&!rslt_rdy.
- TOR pair with rslt_rdy held 1: beats at T+2, T+3; req_rdy high at T+4.
- req_rdy low from T+1 until cycle after last beat handshake; no request pipelining.
- Reset asserted mid-operation: immediate return to reset values, in-flight request lost.

## Configuration
- PMP_TOR_SPLIT_EN defined: non-NAPOT ranges produce the OFF/TOR two-beat sequence above.
- Undefined: non-NAPOT ranges produce the single err beat; OUT1 unreachable and may be removed.

## Test plan
- base=0x0000100, top=0x0000200 -> one beat: pmpaddr=0x00002FF, mode 11, last 1, err 0 (1MB).
- base=0x0000010, top=0x0000011 -> pmpaddr=0x0000020, mode 11, last 1 (4KB).
- base=0x0000000, top=0x10000000 -> pmpaddr=0x0FFFFFFF, mode 11 (full 1TB).
- base=0x0000001, top=0x0000004, macro on -> beat 0x0000002/mode 00/last 0, then 0x0000008/mode 01/last 1; macro off -> single err beat.
- base=0x0000005, top=0x0000005 -> err 1, mode 00, pmpaddr 0, last 1; req_rdy back next cycle after handshake.
- TOR request with rslt_rdy low 5 cycles -> beat 0 outputs stable; flush asserted during OUT1 -> rslt_vld 0 next cycle, req_rdy 1.

Source files
------------

// File: rtl/ct_pmp_napot_enc.sv
// ct_pmp_napot_enc
//    Sequential PMP region encoder. Converts a 4KB-page range [base, top) into
//    the pmpaddr value(s) and address-match mode that make one PMP entry (NAPOT)
//    or an entry pair (OFF + TOR) hit exactly that range. Results stream out over
//    a valid/ready handshake, one beat per pmpaddr write.
//
//    Build option: PMP_TOR_SPLIT_EN
//       defined   : non-NAPOT ranges produce an OFF beat then a TOR beat
//       undefined : non-NAPOT ranges produce a single error beat
//
//    Ports
//       cpuclk        core clock, rising edge
//       cpurst        asynchronous active-high reset
//       req_vld       region request valid
//       req_rdy       encoder idle; request taken when req_vld && req_rdy
//       req_base      first page of the region
//       req_top       exclusive end page (2^ADDR_WIDTH allowed)
//       flush         synchronous abort, drops any in-flight result
//       rslt_vld      result beat valid
//       rslt_rdy      consumer accepts the beat
//       rslt_pmpaddr  pmpaddr value (bit 0 is the NAPOT granule bit)
//       rslt_mode     00 OFF, 01 TOR, 11 NAPOT
//       rslt_last     final beat of the request
//       rslt_err      region not encodable (pmpaddr 0, mode OFF)
module ct_pmp_napot_enc #(
   parameter int unsigned ADDR_WIDTH = 28
) (
   input  logic                  cpuclk,
   input  logic                  cpurst,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic [ADDR_WIDTH-1:0] req_base,
   input  logic [ADDR_WIDTH:0]   req_top,
   input  logic                  flush,
   output logic                  rslt_vld,
   input  logic                  rslt_rdy,
   output logic [ADDR_WIDTH:0]   rslt_pmpaddr,
   output logic [1:0]            rslt_mode,
   output logic                  rslt_last,
   output logic                  rslt_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT0 = 2'd2,
      OUT1 = 2'd3
   } state_t;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_TOR   = 2'b01;
   localparam logic [1:0] MODE_NAPOT = 2'b11;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   top_q;

   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH:0]   len_m1;
   logic [ADDR_WIDTH:0]   napot_addr;
   logic                  order_err;
   logic                  is_pow2;
   logic                  is_aligned;
   logic                  napot_ok;

   // For len = 2^n, len-1 is the mask of the low n bits: it doubles as the
   // alignment mask for base and as the run of ones in the NAPOT encoding.
   // Clearing the len bit forces the terminating zero at pmpaddr bit n.
   always_comb begin
      len        = top_q - {1'b0, base_q};
      len_m1     = len - {{ADDR_WIDTH{1'b0}}, 1'b1};
      order_err  = (top_q <= {1'b0, base_q});
      is_pow2    = (len != '0) && ((len & len_m1) == '0);
      is_aligned = ((base_q & len_m1[ADDR_WIDTH-1:0]) == '0);
      napot_ok   = !order_err && is_pow2 && is_aligned;
      napot_addr = ({base_q, 1'b0} | len_m1) & ~len;
   end

   always_ff @(posedge cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state        <= IDLE;
         base_q       <= '0;
         top_q        <= '0;
         req_rdy      <= 1'b1;
         rslt_vld     <= 1'b0;
         rslt_pmpaddr <= '0;
         rslt_mode    <= MODE_OFF;
         rslt_last    <= 1'b0;
         rslt_err     <= 1'b0;
      end else if (flush) begin
         // Abort takes priority over a same-cycle request or handshake.
         state        <= IDLE;
         req_rdy      <= 1'b1;
         rslt_vld     <= 1'b0;
         rslt_pmpaddr <= '0;
         rslt_mode    <= MODE_OFF;
         rslt_last    <= 1'b0;
         rslt_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_vld) begin
                  base_q  <= req_base;
                  top_q   <= req_top;
                  req_rdy <= 1'b0;
                  state   <= CALC;
               end
            end
            CALC: begin
               rslt_vld <= 1'b1;
               state    <= OUT0;
               if (napot_ok) begin
                  rslt_pmpaddr <= napot_addr;
                  rslt_mode    <= MODE_NAPOT;
                  rslt_last    <= 1'b1;
                  rslt_err     <= 1'b0;
               end
`ifdef PMP_TOR_SPLIT_EN
               // A TOR top of 2^ADDR_WIDTH does not fit in pmpaddr, so it
               // falls through to the error beat.
               else if (!order_err && !top_q[ADDR_WIDTH]) begin
                  rslt_pmpaddr <= {base_q, 1'b0};
                  rslt_mode    <= MODE_OFF;
                  rslt_last    <= 1'b0;
                  rslt_err     <= 1'b0;
               end
`endif
               else begin
                  rslt_pmpaddr <= '0;
                  rslt_mode    <= MODE_OFF;
                  rslt_last    <= 1'b1;
                  rslt_err     <= 1'b1;
               end
            end
            OUT0: begin
               if (rslt_rdy) begin
                  if (rslt_last) begin
                     rslt_vld <= 1'b0;
                     req_rdy  <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     rslt_pmpaddr <= {top_q[ADDR_WIDTH-1:0], 1'b0};
                     rslt_mode    <= MODE_TOR;
                     rslt_last    <= 1'b1;
                     state        <= OUT1;
                  end
               end
            end
            OUT1: begin
               if (rslt_rdy) begin
                  rslt_vld <= 1'b0;
                  req_rdy  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
